mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single Avalon-style unified memory port (address/read/write/writedata/byteenable/readdata/waitrequest) between the CPU instruction-fetch port and the data port.
- Sits between the MIPS core's two bus masters and the RAM.
- Registers all memory-side request signals and arbitrates round-robin on ties.
- Bounds every transaction with a timeout that raises a sticky error.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles a granted transaction may wait on mem_waitrequest before being aborted (must be >= 2).
- TIMEOUT_W, 11, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_address  in  32  instruction fetch byte address.
- i_read  in  1  instruction fetch request; held until i_waitrequest is low.
- i_waitrequest  out  1  high while the instruction request is not complete.
- i_readdata  out  32  fetch data; valid in the completion cycle.
- d_address  in  32  data byte address.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_writedata  in  32  store data.
- d_byteenable  in  4  byte lanes; passed through uninterpreted.
- d_waitrequest  out  1  high while the data request is not complete.
- d_readdata  out  32  load data; valid in the completion cycle.
- mem_address  out  32  registered memory address.
- mem_read  out  1  registered memory read strobe.
- mem_write  out  1  registered memory write strobe.
- mem_writedata  out  32  registered store data.
- mem_byteenable  out  4  registered lanes; 4'b1111 for fetches.
- mem_readdata  in  32  memory read data.
- mem_waitrequest  in  1  memory stall.
- bus_error  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset: reset asserted at any time, including mid-transaction, immediately forces:
  - state=IDLE, last_grant=INSTR, timeout counter=0
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0
  - bus_error=0
  - An in-flight transaction is abandoned; no completion is signalled.
- Requester handshake:
  - i_waitrequest = i_read && !(state==BUS_I && i_done).
  - d_waitrequest = (d_read||d_write) && !(state==BUS_D && d_done).
  - Both are 0 when the port is idle.
- Completion: in a BUS_x state, the transaction completes on the rising edge where the active mem strobe is high and mem_waitrequest is low.
  - x_done is that combinational condition, or the timeout firing.
- Read data:
  - i_readdata/d_readdata equal mem_readdata during a normal completion cycle, and 32'h0 on timeout completion.
  - Outside the completion cycle the value is don't-care; drive mem_readdata.
- States:
  - IDLE: if only one port is requesting, grant it. If both, grant the port != last_grant. On the grant edge, register the requester's address/data/byteenable into the mem_* signals and raise mem_read or mem_write. Set last_grant and go to BUS_I or BUS_D.
  - BUS_I / BUS_D: hold the mem_* signals stable. Each cycle with waitrequest high, increment the timeout counter. On completion, drop the strobes, clear the counter and return to IDLE.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 with mem_waitrequest still high, that cycle is a forced completion. bus_error is set at the edge.
- Latency:
  - A request first visible in IDLE during cycle N drives the mem strobe in cycle N+1.
  - With a zero-wait memory, completion is in cycle N+1.
  - One IDLE bubble always separates consecutive transactions, so peak throughput is 1 transaction per 2 cycles.
- d_read && d_write together: write wins and the read is ignored.
- A requester dropping its request mid-transaction is a protocol violation. The arbiter still finishes the memory transaction and discards the result.
- A request arriving for the port that is not granted waits, with its waitrequest high, until the next IDLE arbitration.
- A fetch always drives mem_byteenable=4'b1111 and mem_writedata=0.

Decomposition:
- Shared package mem_bus_pkg:
  - enum arb_state_t {IDLE, BUS_I, BUS_D}
  - enum grant_t {INSTR, DATA}
  - localparam BE_ALL=4'b1111
- Sub-module mem_bus_timeout: a loadable counter with clear/enable inputs and an expire output.

Test Plan:
- Fetch only, zero-wait RAM, i_address=32'hBFC00000, RAM word 32'h2402000A -> mem_read high one cycle after request; i_waitrequest low with i_readdata=32'h2402000A in that cycle; mem_byteenable=4'hF.
- Simultaneous i_read and d_write after reset (d_address=32'h00000010, d_writedata=32'hDEADBEEF) -> data granted first. The write is issued, then a bubble, then the fetch; i_waitrequest stays high throughout the write.
- Both ports continuously requesting for 8 transactions -> grants alternate D,I,D,I...; no port is starved.
- Memory holds waitrequest for 3 cycles on d_read -> mem_* signals stay stable for 4 cycles; d_waitrequest falls only in the cycle where mem_waitrequest is low; d_readdata is correct.
- TIMEOUT_CYCLES=8 with mem_waitrequest stuck high on a fetch -> forced completion after 8 cycles; i_readdata=0; bus_error=1 and stays 1 until reset.
- Reset pulsed mid-BUS_D -> mem_write=0 and bus_error=0 immediately (asynchronously); state is IDLE; the next request is served normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types for the fetch/data memory bus arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} arb_state_t;
  typedef enum logic {INSTR, DATA} grant_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_bus_timeout.sv
// rtl/mem_bus_timeout.sv - loadable wait counter that flags the last allowed stall cycle
module mem_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_value,
  input  logic                 enable,
  output logic                 expire
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry only counts while still stalled, so a clean finish on the last cycle wins.
  assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data masters
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  arb_state_t  state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic [3:0]  mem_byteenable_q, mem_byteenable_d;
  logic        bus_error_q, bus_error_d;

  logic i_req, d_req, busy, expire, done, grant_any;

  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign busy      = (state_q != IDLE);
  assign grant_any = !busy && (i_req || d_req);
  assign done      = busy && (((mem_read_q || mem_write_q) && !mem_waitrequest) || expire);

  mem_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear      (done),
    .load       (grant_any),
    .load_value ({TIMEOUT_W{1'b0}}),
    .enable     (busy && mem_waitrequest),
    .expire     (expire)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    mem_address_d    = mem_address_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_writedata_d  = mem_writedata_q;
    mem_byteenable_d = mem_byteenable_q;
    bus_error_d      = bus_error_q;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (i_req && (!d_req || last_grant_q == DATA)) begin
          state_d          = BUS_I;
          last_grant_d     = INSTR;
          mem_address_d    = i_address;
          mem_read_d       = 1'b1;
          mem_write_d      = 1'b0;
          mem_writedata_d  = '0;
          mem_byteenable_d = BE_ALL;
        end else if (d_req) begin
          state_d          = BUS_D;
          last_grant_d     = DATA;
          mem_address_d    = d_address;
          mem_write_d      = d_write;
          mem_read_d       = d_read && !d_write;
          mem_writedata_d  = d_writedata;
          mem_byteenable_d = d_byteenable;
        end
      end
      BUS_I, BUS_D: begin
        if (done) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (expire) begin
            bus_error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= INSTR;
      mem_address_q    <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
      bus_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      mem_address_q    <= mem_address_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
      bus_error_q      <= bus_error_d;
    end
  end

  assign i_waitrequest  = i_req && !((state_q == BUS_I) && done);
  assign d_waitrequest  = d_req && !((state_q == BUS_D) && done);
  // An aborted transaction returns zero rather than whatever the stalled memory drives.
  assign i_readdata     = expire ? 32'h0 : mem_readdata;
  assign d_readdata     = expire ? 32'h0 : mem_readdata;

  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int TO = 8;
  localparam int GI = 0;
  localparam int GD = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address, d_address, d_writedata, mem_readdata;
  logic        i_read, d_read, d_write, mem_waitrequest;
  logic [3:0]  d_byteenable;
  logic        i_waitrequest, d_waitrequest, mem_read, mem_write, bus_error;
  logic [31:0] i_readdata, d_readdata, mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;

  int tests = 0;
  int fails = 0;
  int model_last = GI;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .bus_error(bus_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_address = '0; i_read = 0; d_address = '0; d_read = 0; d_write = 0;
    d_writedata = '0; d_byteenable = '0; mem_waitrequest = 0; mem_readdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    tick();
    @(negedge clk);
    tests++;
    if ({mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, bus_error, i_waitrequest, d_waitrequest} !== 73'h0)
      begin fails++; $display("FAIL reset_outputs: got %h required 0", {mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, bus_error}); end
    i_read = 1;
    tick();
    @(negedge clk);
    tests++;
    if ({mem_read, i_waitrequest} !== 2'b01)
      begin fails++; $display("FAIL reset_hold: got rd/iw %b required 01", {mem_read, i_waitrequest}); end
    i_read = 0;
    tick();
    reset = 0;
    model_last = GI;
  endtask

  task automatic test_fetch();
    i_read = 1; i_address = 32'hBFC00000; mem_readdata = 32'h2402000A;
    @(negedge clk);
    tests++;
    if ({i_waitrequest, mem_read} !== 2'b10)
      begin fails++; $display("FAIL fetch_req: got iw/rd %b required 10", {i_waitrequest, mem_read}); end
    tick();
    @(negedge clk);
    tests++;
    if ({mem_read, mem_write, mem_address, mem_byteenable, mem_writedata, i_waitrequest, i_readdata} !==
        {1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 1'b0, 32'h2402000A})
      begin fails++; $display("FAIL fetch_done: got rd=%b adr=%h be=%h iw=%b rdata=%h", mem_read, mem_address, mem_byteenable, i_waitrequest, i_readdata); end
    tick();
    i_read = 0;
    @(negedge clk);
    tests++;
    if (mem_read !== 1'b0)
      begin fails++; $display("FAIL fetch_drop: got mem_read %b required 0", mem_read); end
    tick();
    model_last = GI;
  endtask

  task automatic test_both_write_first();
    reset = 1; idle_inputs(); tick(); reset = 0; model_last = GI;
    i_read = 1; i_address = 32'h00400000; d_write = 1; d_address = 32'h00000010;
    d_writedata = 32'hDEADBEEF; d_byteenable = 4'hF; mem_readdata = 32'h11112222;
    @(negedge clk);
    tests++;
    if ({i_waitrequest, d_waitrequest, mem_read, mem_write} !== 4'b1100)
      begin fails++; $display("FAIL tie_req: got %b required 1100", {i_waitrequest, d_waitrequest, mem_read, mem_write}); end
    tick();
    @(negedge clk);
    tests++;
    if ({mem_write, mem_read, mem_address, mem_writedata, mem_byteenable, d_waitrequest, i_waitrequest} !==
        {1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1})
      begin fails++; $display("FAIL tie_write: got wr=%b rd=%b adr=%h wd=%h dw=%b iw=%b", mem_write, mem_read, mem_address, mem_writedata, d_waitrequest, i_waitrequest); end
    tick();
    d_write = 0;
    @(negedge clk);
    tests++;
    if ({mem_read, mem_write, i_waitrequest} !== 3'b001)
      begin fails++; $display("FAIL tie_bubble: got %b required 001", {mem_read, mem_write, i_waitrequest}); end
    tick();
    @(negedge clk);
    tests++;
    if ({mem_read, mem_write, mem_address, mem_byteenable, i_waitrequest, i_readdata} !==
        {1'b1, 1'b0, 32'h00400000, 4'hF, 1'b0, 32'h11112222})
      begin fails++; $display("FAIL tie_fetch: got rd=%b adr=%h iw=%b rdata=%h", mem_read, mem_address, i_waitrequest, i_readdata); end
    tick();
    i_read = 0;
    model_last = GI;
    tick();
  endtask

  task automatic test_alternate();
    int done_cnt = 0;
    int waits = 0;
    int who, expect_who;
    bit refresh;
    i_read = 1; d_read = 1; i_address = $urandom; d_address = $urandom; d_byteenable = 4'h3;
    for (int c = 0; c < 80 && done_cnt < 8; c++) begin
      mem_waitrequest = (waits >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
      mem_readdata = $urandom;
      refresh = 0;
      @(negedge clk);
      if (!i_waitrequest || !d_waitrequest) begin
        who = !d_waitrequest ? GD : GI;
        expect_who = (model_last == GI) ? GD : GI;
        tests++;
        if (who != expect_who || (!i_waitrequest && !d_waitrequest))
          begin fails++; $display("FAIL alt_grant %0d: got port %0d (iw=%b dw=%b) required %0d", done_cnt, who, i_waitrequest, d_waitrequest, expect_who); end
        tests++;
        if (who == GD ? ({mem_address, d_readdata} !== {d_address, mem_readdata})
                      : ({mem_address, i_readdata} !== {i_address, mem_readdata}))
          begin fails++; $display("FAIL alt_data %0d: got adr=%h required %h", done_cnt, mem_address, who == GD ? d_address : i_address); end
        model_last = who;
        done_cnt++;
        refresh = 1;
      end
      waits = mem_waitrequest ? waits + 1 : 0;
      tick();
      if (refresh) begin
        if (who == GD) d_address = $urandom; else i_address = $urandom;
      end
    end
    tests++;
    if (done_cnt != 8)
      begin fails++; $display("FAIL alt_count: got %0d completions required 8", done_cnt); end
    i_read = 0; d_read = 0; mem_waitrequest = 0;
    tick();
  endtask

  task automatic test_wait_states();
    d_read = 1; d_address = 32'h00000100; d_byteenable = 4'hA; mem_waitrequest = 1; mem_readdata = 32'h12345678;
    @(negedge clk);
    tests++;
    if ({mem_read, d_waitrequest} !== 2'b01)
      begin fails++; $display("FAIL ws_req: got %b required 01", {mem_read, d_waitrequest}); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) mem_waitrequest = 0;
      @(negedge clk);
      tests++;
      if ({mem_read, mem_write, mem_address, mem_byteenable, d_waitrequest} !== {1'b1, 1'b0, 32'h100, 4'hA, (k != 4)})
        begin fails++; $display("FAIL ws_cycle%0d: got rd=%b adr=%h be=%h dw=%b", k, mem_read, mem_address, mem_byteenable, d_waitrequest); end
    end
    tests++;
    if (d_readdata !== 32'h12345678)
      begin fails++; $display("FAIL ws_rdata: got %h required 12345678", d_readdata); end
    tick();
    d_read = 0;
    model_last = GD;
    @(negedge clk);
    tests++;
    if (mem_read !== 1'b0)
      begin fails++; $display("FAIL ws_drop: got mem_read %b required 0", mem_read); end
    tick();
  endtask

  task automatic test_timeout();
    int done_at = -1;
    i_read = 1; i_address = 32'h00001000; mem_waitrequest = 1; mem_readdata = 32'hFFFFFFFF;
    for (int k = 0; k < 20 && done_at < 0; k++) begin
      @(negedge clk);
      if (!i_waitrequest) begin
        done_at = k;
        tests++;
        if ({i_readdata, bus_error, mem_read} !== {32'h0, 1'b0, 1'b1})
          begin fails++; $display("FAIL to_done: got rdata=%h err=%b rd=%b required 0/0/1", i_readdata, bus_error, mem_read); end
      end
      tick();
    end
    tests++;
    if (done_at != TO)
      begin fails++; $display("FAIL to_latency: got completion at %0d required %0d", done_at, TO); end
    i_read = 0; mem_waitrequest = 0;
    model_last = GI;
    repeat (3) tick();
    @(negedge clk);
    tests++;
    if ({bus_error, mem_read} !== 2'b10)
      begin fails++; $display("FAIL to_sticky: got err/rd %b required 10", {bus_error, mem_read}); end
    tick();
  endtask

  task automatic test_reset_mid();
    d_write = 1; d_address = 32'h00000020; d_writedata = 32'hCAFEF00D; d_byteenable = 4'hF; mem_waitrequest = 1;
    tick();
    @(negedge clk);
    tests++;
    if (mem_write !== 1'b1)
      begin fails++; $display("FAIL rst_pre: got mem_write %b required 1", mem_write); end
    #1 reset = 1;
    #1;
    tests++;
    if ({mem_write, mem_address, bus_error, d_waitrequest} !== {1'b0, 32'h0, 1'b0, 1'b1})
      begin fails++; $display("FAIL rst_async: got wr=%b adr=%h err=%b dw=%b", mem_write, mem_address, bus_error, d_waitrequest); end
    tick();
    reset = 0; mem_waitrequest = 0; model_last = GI;
    @(negedge clk);
    tests++;
    if ({mem_write, d_waitrequest} !== 2'b01)
      begin fails++; $display("FAIL rst_idle: got %b required 01", {mem_write, d_waitrequest}); end
    tick();
    @(negedge clk);
    tests++;
    if ({mem_write, mem_address, mem_writedata, d_waitrequest} !== {1'b1, 32'h20, 32'hCAFEF00D, 1'b0})
      begin fails++; $display("FAIL rst_after: got wr=%b adr=%h wd=%h dw=%b", mem_write, mem_address, mem_writedata, d_waitrequest); end
    tick();
    d_write = 0;
    model_last = GD;
    tick();
  endtask

  task automatic test_random();
    bit busy, idone, ddone, idone_prev, ddone_prev, both;
    int g, waits, n_i, n_d;
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    logic        erd, ewr;
    busy = 0; idone_prev = 0; ddone_prev = 0; g = GI; waits = 0; n_i = 0; n_d = 0;
    ea = '0; ewd = '0; ebe = '0; erd = 0; ewr = 0;
    for (int c = 0; c < 300; c++) begin
      if (idone_prev) i_read = 0;
      if (ddone_prev) begin d_read = 0; d_write = 0; end
      if (!i_read && $urandom_range(0, 2) == 0) begin i_read = 1; i_address = $urandom; end
      if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       d_read = 1;
          1:       d_write = 1;
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_address = $urandom; d_writedata = $urandom; d_byteenable = 4'($urandom);
      end
      mem_waitrequest = (waits < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_readdata = $urandom;
      @(negedge clk);
      idone = busy && g == GI && !mem_waitrequest;
      ddone = busy && g == GD && !mem_waitrequest;
      tests++;
      if (busy ? ({mem_read, mem_write, mem_address, mem_writedata, mem_byteenable} !== {erd, ewr, ea, ewd, ebe})
               : ({mem_read, mem_write} !== 2'b00))
        begin fails++; $display("FAIL rand_mem c%0d: got rd=%b wr=%b adr=%h wd=%h be=%h required %b %b %h %h %h", c, mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, busy && erd, busy && ewr, ea, ewd, ebe); end
      tests++;
      if ({i_waitrequest, d_waitrequest} !== {i_read && !idone, (d_read || d_write) && !ddone})
        begin fails++; $display("FAIL rand_wait c%0d: got iw/dw %b required %b", c, {i_waitrequest, d_waitrequest}, {i_read && !idone, (d_read || d_write) && !ddone}); end
      if (idone) begin
        n_i++; tests++;
        if (i_readdata !== mem_readdata) begin fails++; $display("FAIL rand_irdata c%0d: got %h required %h", c, i_readdata, mem_readdata); end
      end
      if (ddone) begin
        n_d++; tests++;
        if (d_readdata !== mem_readdata) begin fails++; $display("FAIL rand_drdata c%0d: got %h required %h", c, d_readdata, mem_readdata); end
      end
      if (busy) begin
        if (idone || ddone) begin busy = 0; waits = 0; end
        else waits++;
      end else if (i_read || d_read || d_write) begin
        both = i_read && (d_read || d_write);
        if (both) g = (model_last == GI) ? GD : GI;
        else      g = i_read ? GI : GD;
        model_last = g; busy = 1; waits = 0;
        if (g == GI) begin ea = i_address; erd = 1; ewr = 0; ewd = '0; ebe = 4'hF; end
        else begin ea = d_address; ewr = d_write; erd = d_read && !d_write; ewd = d_writedata; ebe = d_byteenable; end
      end
      idone_prev = idone; ddone_prev = ddone;
      tick();
    end
    tests++;
    if (n_i == 0 || n_d == 0)
      begin fails++; $display("FAIL rand_starve: got %0d fetches %0d data required both nonzero", n_i, n_d); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_both_write_first();
    test_alternate();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
